// File: rtl/pc_sequencer_if.sv
// Fetch-PC bus between the fetch-stage control and pc_sequencer.
// slave modport: the sequencer (takes redirect requests, drives PC/RAS status).
// master modport: the fetch-stage control (drives requests, observes PC/RAS status).
// Requests:  PCoff, ExcTaken/ExcVector, BranchTaken/BranchTarget,
//            JumpTaken/JumpLink/JumpTarget, ReturnTaken.
// Status:    PCResult, PCPlusInc, Misaligned, RasCount, RasEmpty, RasFull, RasUnderflow.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic             PCoff;
    logic             ExcTaken;
    logic [WIDTH-1:0] ExcVector;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             JumpTaken;
    logic             JumpLink;
    logic [WIDTH-1:0] JumpTarget;
    logic             ReturnTaken;

    logic [WIDTH-1:0] PCResult;
    logic [WIDTH-1:0] PCPlusInc;
    logic             Misaligned;
    logic [CNT_W-1:0] RasCount;
    logic             RasEmpty;
    logic             RasFull;
    logic             RasUnderflow;

    modport slave (
        input  PCoff, ExcTaken, ExcVector, BranchTaken, BranchTarget,
               JumpTaken, JumpLink, JumpTarget, ReturnTaken,
        output PCResult, PCPlusInc, Misaligned, RasCount, RasEmpty, RasFull,
               RasUnderflow
    );

    modport master (
        output PCoff, ExcTaken, ExcVector, BranchTaken, BranchTarget,
               JumpTaken, JumpLink, JumpTarget, ReturnTaken,
        input  PCResult, PCPlusInc, Misaligned, RasCount, RasEmpty, RasFull,
               RasUnderflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised next-PC selection and a
// circular return-address stack.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - synchronous active-high reset
//   bus    - pc_sequencer_if.slave: redirect requests in, PC and RAS status out
// Next-PC priority: exception > stall > branch > jump(/call) > return > PC+INC.
// INC must be a power of two no larger than 2^(WIDTH-1); RAS_DEPTH must be >= 2.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] tp_q;
    logic [PTR_W-1:0] tp_inc, tp_dec;
    logic             uf_q, uf_d;
    logic             push, pop, flush;
    logic             ras_empty, ras_full;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];

    // Sequential address and pointer neighbours (pointer wraps mod RAS_DEPTH)
    always_comb begin
        pc_plus = pc_q + INC_W;
        tp_inc  = (tp_q == PTR_MAX) ? '0 : tp_q + PTR_W'(1);
        tp_dec  = (tp_q == '0) ? PTR_MAX : tp_q - PTR_W'(1);
    end

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);

    // Next-PC arbitration; losing requests produce no RAS side effect
    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        uf_d  = 1'b0;
        if (bus.ExcTaken) begin
            pc_d  = bus.ExcVector;
            flush = 1'b1;
        end else if (bus.PCoff) begin
            pc_d = pc_q;
        end else if (bus.BranchTaken) begin
            pc_d = bus.BranchTarget;
        end else if (bus.JumpTaken) begin
            pc_d = bus.JumpTarget;
            push = bus.JumpLink;
        end else if (bus.ReturnTaken) begin
            if (!ras_empty) begin
                pc_d = stack_q[tp_dec];
                pop  = 1'b1;
            end else begin
                pc_d = pc_plus;
                uf_d = 1'b1;
            end
        end else begin
            pc_d = pc_plus;
        end
    end

    // PC, RAS occupancy/pointer and underflow pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            tp_q  <= '0;
            uf_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
            if (flush) begin
                cnt_q <= '0;
                tp_q  <= '0;
            end else if (push) begin
                tp_q <= tp_inc;
                // Overflow silently overwrites the oldest entry
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                tp_q  <= tp_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // RAS storage carries no reset; contents are only read when counted valid
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            stack_q[tp_q] <= pc_plus;
        end
    end

    assign bus.PCResult     = pc_q;
    assign bus.PCPlusInc    = pc_plus;
    assign bus.Misaligned   = |(pc_q & (INC_W - WIDTH'(1)));
    assign bus.RasCount     = cnt_q;
    assign bus.RasEmpty     = ras_empty;
    assign bus.RasFull      = ras_full;
    assign bus.RasUnderflow = uf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit instance for reset, stall,
// exception, call/return, RAS overflow/underflow and priority; an 8-bit
// instance for address wrap and misalignment.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_m;
    logic rst_s;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned due;
        bit          dut;     // 0: 32-bit instance, 1: 8-bit instance
        logic [31:0] pc;
        int          cnt;
        bit          uf;
        string       name;
    } exp_t;

    exp_t q[$];

    pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) m ();
    pc_sequencer_if #(.WIDTH(8),  .RAS_DEPTH(4)) s ();

    pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) u_main (
        .Clk   (clk),
        .Reset (rst_m),
        .bus   (m)
    );

    pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h0), .INC(4), .RAS_DEPTH(4)) u_small (
        .Clk   (clk),
        .Reset (rst_s),
        .bus   (s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string name, string fld, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", name, fld, act, exp);
        end
    endfunction

    // Monitor: compares every expectation that falls due at this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [31:0] a_pc, a_inc, e_inc;
            logic [31:0] a_cnt;
            logic        a_mis, a_emp, a_full, a_uf;
            e = q.pop_front();
            if (e.due != cyc) begin
                chk(e.name, "stale", 32'(cyc), 32'(e.due));
            end else begin
                if (!e.dut) begin
                    a_pc = m.PCResult; a_inc = m.PCPlusInc; a_mis = m.Misaligned;
                    a_cnt = 32'(m.RasCount); a_emp = m.RasEmpty; a_full = m.RasFull;
                    a_uf = m.RasUnderflow;
                    e_inc = e.pc + 32'd4;
                end else begin
                    a_pc = 32'(s.PCResult); a_inc = 32'(s.PCPlusInc); a_mis = s.Misaligned;
                    a_cnt = 32'(s.RasCount); a_emp = s.RasEmpty; a_full = s.RasFull;
                    a_uf = s.RasUnderflow;
                    e_inc = (e.pc + 32'd4) & 32'hFF;
                end
                chk(e.name, "pc", a_pc, e.pc);
                chk(e.name, "pcplusinc", a_inc, e_inc);
                chk(e.name, "misaligned", 32'(a_mis), 32'(e.pc[1:0] != 2'b00));
                chk(e.name, "rascount", a_cnt, 32'(e.cnt));
                chk(e.name, "rasempty", 32'(a_emp), 32'(e.cnt == 0));
                chk(e.name, "rasfull", 32'(a_full), 32'(e.cnt == 4));
                chk(e.name, "underflow", 32'(a_uf), 32'(e.uf));
            end
        end
    end

    task automatic clear_m();
        m.PCoff = 0; m.ExcTaken = 0; m.ExcVector = '0; m.BranchTaken = 0;
        m.BranchTarget = '0; m.JumpTaken = 0; m.JumpLink = 0; m.JumpTarget = '0;
        m.ReturnTaken = 0;
    endtask

    task automatic clear_s();
        s.PCoff = 0; s.ExcTaken = 0; s.ExcVector = '0; s.BranchTaken = 0;
        s.BranchTarget = '0; s.JumpTaken = 0; s.JumpLink = 0; s.JumpTarget = '0;
        s.ReturnTaken = 0;
    endtask

    // Queue the state expected after the next edge, then advance one cycle
    task automatic step(input bit dut, input string name, input logic [31:0] pc,
                        input int cnt, input bit uf);
        exp_t e;
        e.due = cyc + 1; e.dut = dut; e.pc = pc; e.cnt = cnt; e.uf = uf; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
        clear_m();
        clear_s();
        rst_m = 1'b0;
    endtask

    task automatic call_m(input logic [31:0] tgt);
        m.JumpTaken = 1; m.JumpLink = 1; m.JumpTarget = tgt;
    endtask

    task automatic br_m(input logic [31:0] tgt);
        m.BranchTaken = 1; m.BranchTarget = tgt;
    endtask

    initial begin
        rst_m = 1'b1;
        rst_s = 1'b1;
        clear_m();
        clear_s();
        @(posedge clk);
        #1;

        // Reset and sequential fetch
        rst_m = 1; step(0, "reset0", 32'h0, 0, 0);
        rst_m = 1; step(0, "reset1", 32'h0, 0, 0);
        step(0, "seq4", 32'h4, 0, 0);
        step(0, "seq8", 32'h8, 0, 0);
        step(0, "seq12", 32'hC, 0, 0);
        call_m(32'h8); step(0, "call_pre_stall", 32'h8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            m.PCoff = 1; br_m(32'h40); step(0, "stall_hold", 32'h8, 1, 0);
        end
        m.PCoff = 1; br_m(32'h40); m.ExcTaken = 1; m.ExcVector = 32'h80;
        step(0, "exc_in_stall", 32'h80, 0, 0);
        step(0, "after_exc", 32'h84, 0, 0);

        // Call/return and nesting
        rst_m = 1; step(0, "reset_b", 32'h0, 0, 0);
        br_m(32'h10); step(0, "br_0x10", 32'h10, 0, 0);
        call_m(32'h100); step(0, "call_0x100", 32'h100, 1, 0);
        step(0, "in_callee", 32'h104, 1, 0);
        m.ReturnTaken = 1; step(0, "ret_0x14", 32'h14, 0, 0);
        br_m(32'h10); step(0, "br_0x10b", 32'h10, 0, 0);
        call_m(32'h100); step(0, "nest1", 32'h100, 1, 0);
        call_m(32'h200); step(0, "nest2", 32'h200, 2, 0);
        call_m(32'h300); step(0, "nest3", 32'h300, 3, 0);
        m.ReturnTaken = 1; step(0, "nret_0x204", 32'h204, 2, 0);
        m.ReturnTaken = 1; step(0, "nret_0x104", 32'h104, 1, 0);
        m.ReturnTaken = 1; step(0, "nret_0x14", 32'h14, 0, 0);

        // RAS overflow then underflow
        rst_m = 1; step(0, "reset_c", 32'h0, 0, 0);
        call_m(32'h1000); step(0, "ov_call1", 32'h1000, 1, 0);
        call_m(32'h2000); step(0, "ov_call2", 32'h2000, 2, 0);
        call_m(32'h3000); step(0, "ov_call3", 32'h3000, 3, 0);
        call_m(32'h4000); step(0, "ov_call4", 32'h4000, 4, 0);
        call_m(32'h5000); step(0, "ov_call5", 32'h5000, 4, 0);
        m.ReturnTaken = 1; step(0, "ov_ret1", 32'h4004, 3, 0);
        m.ReturnTaken = 1; step(0, "ov_ret2", 32'h3004, 2, 0);
        m.ReturnTaken = 1; step(0, "ov_ret3", 32'h2004, 1, 0);
        m.ReturnTaken = 1; step(0, "ov_ret4", 32'h1004, 0, 0);
        m.ReturnTaken = 1; step(0, "underflow", 32'h1008, 0, 1);
        step(0, "uf_cleared", 32'h100C, 0, 0);

        // Priority and reset dominance
        rst_m = 1; step(0, "reset_d", 32'h0, 0, 0);
        call_m(32'h50); step(0, "pri_call", 32'h50, 1, 0);
        br_m(32'h60); call_m(32'h70); m.ReturnTaken = 1;
        step(0, "pri_branch", 32'h60, 1, 0);
        m.ReturnTaken = 1; step(0, "pri_ret_intact", 32'h4, 0, 0);
        m.JumpTaken = 1; m.JumpTarget = 32'h90; m.ReturnTaken = 1;
        step(0, "jump_beats_ret", 32'h90, 0, 0);
        m.ExcTaken = 1; m.ExcVector = 32'h200; br_m(32'h300);
        step(0, "exc_beats_br", 32'h200, 0, 0);
        m.PCoff = 1; m.ReturnTaken = 1; step(0, "stall_no_uf", 32'h200, 0, 0);
        m.PCoff = 1; rst_m = 1; br_m(32'h44); step(0, "reset_in_stall", 32'h0, 0, 0);
        step(0, "resume", 32'h4, 0, 0);

        // 8-bit wrap and misalignment
        rst_s = 1'b1; step(1, "s_reset", 32'h0, 0, 0);
        rst_s = 1'b0;
        s.BranchTaken = 1; s.BranchTarget = 8'hFC; step(1, "s_br_fc", 32'hFC, 0, 0);
        step(1, "s_wrap", 32'h00, 0, 0);
        s.BranchTaken = 1; s.BranchTarget = 8'h13; step(1, "s_misaligned", 32'h13, 0, 0);
        step(1, "s_mis_seq", 32'h17, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard", "pending", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the pipelined datapath's fetch stage. It holds the fetch PC and selects the next PC each cycle from five sources, in priority order: exception vector, branch target, jump/call target, return-address-stack pop, sequential increment. It honours a fetch stall (`PCoff`) and keeps an internal return-address stack (RAS) so call/return pairs redirect without a register-file read.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `INC`, 4: sequential increment. Must be a power of two, at most 2^(WIDTH-1).
- `RAS_DEPTH`, 4: number of RAS entries. Must be at least 2.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `PCoff`  in  1  stall; when 1, PC holds unless an exception is taken.
- `ExcTaken`  in  1  exception redirect request.
- `ExcVector`  in  WIDTH  exception handler address.
- `BranchTaken`  in  1  resolved taken branch.
- `BranchTarget`  in  WIDTH  branch destination.
- `JumpTaken`  in  1  jump request.
- `JumpLink`  in  1  qualifies `JumpTaken` as a call; pushes `PCResult+INC`.
- `JumpTarget`  in  WIDTH  jump destination.
- `ReturnTaken`  in  1  return request; pops the RAS.
- `PCResult`  out  WIDTH  current fetch PC (registered).
- `PCPlusInc`  out  WIDTH  `PCResult+INC`, combinational, mod 2^WIDTH.
- `Misaligned`  out  1  combinational; 1 when `PCResult` mod `INC` ≠ 0.
- `RasCount`  out  clog2(RAS_DEPTH+1)  valid RAS entries (registered).
- `RasEmpty` / `RasFull`  out  1  `RasCount==0` / `RasCount==RAS_DEPTH`.
- `RasUnderflow`  out  1  registered one-cycle pulse on a return taken with an empty RAS.

## Operation
- **Reset** (on a `Clk` edge with `Reset=1`, overrides everything):
  - `PCResult=RESET_VECTOR`, `RasCount=0`, `RasUnderflow=0`.
  - RAS storage contents are don't-care.
- **Next-PC selection** (first match wins):
  1. `ExcTaken`: `ExcVector`. Applies even when `PCoff=1`. Flushes the RAS (`RasCount` becomes 0).
  2. `PCoff=1`: hold `PCResult`. All lower-priority requests are ignored, with no RAS push or pop; upstream keeps them asserted.
  3. `BranchTaken`: `BranchTarget`.
  4. `JumpTaken`: `JumpTarget`. If `JumpLink=1`, push `PCResult+INC`.
  5. `ReturnTaken`:
     - RAS non-empty: pop the top entry into the PC.
     - RAS empty: `PCResult+INC`, and `RasUnderflow` pulses on the next cycle.
  6. Otherwise: `PCResult+INC`.
- A lower-priority request that loses arbitration has no side effect. For example, a branch and a return in the same cycle leave the RAS untouched.
- **RAS** is a circular stack with top pointer `tp`:
  - Push writes `stack[tp]`, then increments `tp` mod `RAS_DEPTH`.
  - Pop decrements `tp`, then reads `stack[tp]`.
  - Overflow (push when full): overwrites the oldest entry; `RasCount` stays at `RAS_DEPTH`. No error flag.
- **Arithmetic**: all additions are unsigned and wrap mod 2^WIDTH. `PCResult = 2^WIDTH - INC` followed by a sequential step gives 0.
- **Misaligned** is reported only. The PC still loads the unaligned target.

## Timing
- All state updates on the rising `Clk` edge. A redirect presented in cycle N appears on `PCResult` in cycle N+1 (one-cycle latency).
- `PCPlusInc`, `Misaligned`, `RasEmpty` and `RasFull` follow the registered state combinationally, within the same cycle.
- A push and its matching pop may occur in consecutive cycles. The pop returns the just-pushed value; no bypass is needed because state is registered.
- `RasUnderflow` is high for exactly one cycle per underflowing return.
- Reset asserted mid-stall or mid-redirect wins that edge; normal operation resumes on the first edge with `Reset=0`.

## Test plan
- **Reset and sequential fetch**: `Reset=1` for 2 cycles, then idle. `PCResult` reads 0, 4, 8, 12 on successive cycles; `RasEmpty=1`.
- **Stall vs exception**:
  - At PC=8, `PCoff=1` for 3 cycles with `BranchTaken=1`, `BranchTarget=0x40`: PC holds at 8.
  - Then `ExcTaken=1`, `ExcVector=0x80` while still stalled: PC is 0x80 next cycle and `RasCount=0`.
- **Call/return**:
  - At PC=0x10, call with `JumpTarget=0x100`: PC=0x100, `RasCount=1`.
  - Return 2 cycles later: PC=0x14, `RasCount=0`.
  - Nested calls from 0x10, 0x100 and 0x200 return in order to 0x204, 0x104, 0x14.
- **RAS overflow and underflow** (`RAS_DEPTH=4`):
  - Five calls leave `RasFull=1`, `RasCount=4`.
  - Four returns yield the 5th, 4th, 3rd and 2nd return addresses.
  - A 5th return at PC=P gives PC=P+4, `RasUnderflow` pulses once, and `RasCount` stays 0.
- **Priority**: `BranchTaken`, `JumpTaken` with `JumpLink`, and `ReturnTaken` all asserted in one cycle. PC takes `BranchTarget`; `RasCount` is unchanged.
- **Wrap and alignment** (`WIDTH=8`, `INC=4`):
  - `PCResult=0xFC`, then a sequential step gives 0x00.
  - A branch to 0x13 gives PC=0x13 with `Misaligned=1`.
